fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the CMOS 6502 core, the successor to the fixed fetch/decode sequencing inside the control unit. After reset it loads the program counter from the reset vector, then streams sequential opcode/operand bytes from memory into a DEPTH-entry prefetch queue. The decoder drains the queue through a valid/ready handshake. A redirect port lets branches and jumps flush the queue and restart fetch at a new address.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch front-end bus: memory read port, redirect port and decoder-facing byte stream.
interface fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ins_valid;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_ready;
  logic [ADDR_W-1:0] fetch_pc;
  logic [1:0]        fetch_state;

  modport master (
    output mem_addr, mem_rd, ins_valid, ins_data, ins_pc, fetch_pc, fetch_state,
    input  mem_data, redirect, redirect_pc, ins_ready
  );

  modport slave (
    input  mem_addr, mem_rd, ins_valid, ins_data, ins_pc, fetch_pc, fetch_state,
    output mem_data, redirect, redirect_pc, ins_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// 6502 instruction-fetch front end: reset-vector load, credit-based prefetch
// into a DEPTH-entry queue, valid/ready drain and redirect flush.
module fetch_unit #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter int                DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic     clk_in,
  input  logic     reset_n,
  fetch_if.master  bus
);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {VEC_LO = 2'd0, VEC_HI = 2'd1, VEC_LOAD = 2'd2, RUN = 2'd3} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc, mem_addr, ret_pc;
  logic              mem_rd, inflight, lo_valid;
  logic [DATA_W-1:0] vec_lo;
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;
  logic [PW+1:0]     credit;
  logic              push, pop, can_issue;
  logic [ADDR_W-1:0] vector;

  // Slots already spoken for: queued bytes, the byte landing now, and the read on the bus.
  assign credit    = (PW+2)'(count) + (PW+2)'(inflight) + (PW+2)'(mem_rd);
  assign can_issue = (credit < (PW+2)'(DEPTH)) && !bus.redirect;
  assign push      = inflight;
  assign pop       = (count != '0) && bus.ins_ready;
  assign vector    = {bus.mem_data, vec_lo};

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state    <= VEC_LO;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      fetch_pc <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= 1'b0;
      ret_pc   <= '0;
      vec_lo   <= '0;
      lo_valid <= 1'b0;
    end else begin
      mem_rd   <= 1'b0;
      ret_pc   <= mem_addr;
      // Only run-mode reads land in the queue, and a redirect kills the one on the bus.
      inflight <= mem_rd && (state == RUN) && !bus.redirect;
      case (state)
        VEC_LO: begin
          mem_rd   <= 1'b1;
          mem_addr <= RESET_VECTOR;
          state    <= VEC_HI;
        end
        VEC_HI: begin
          mem_rd   <= 1'b1;
          mem_addr <= RESET_VECTOR + ADDR_W'(1);
          lo_valid <= 1'b0;
          state    <= VEC_LOAD;
        end
        VEC_LOAD: begin
          if (!lo_valid) begin
            vec_lo   <= bus.mem_data;
            lo_valid <= 1'b1;
          end else begin
            // High byte is on mem_data now; issue the first opcode read straight away.
            mem_rd   <= 1'b1;
            mem_addr <= vector;
            fetch_pc <= vector + ADDR_W'(1);
            state    <= RUN;
          end
        end
        RUN: begin
          if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
          end else begin
            if (can_issue) begin
              mem_rd   <= 1'b1;
              mem_addr <= fetch_pc;
              fetch_pc <= fetch_pc + ADDR_W'(1);
            end
            if (push) begin
              q_data[wr_ptr] <= bus.mem_data;
              q_pc[wr_ptr]   <= ret_pc;
              wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
              2'b10:   count <= count + (PW+1)'(1);
              2'b01:   count <= count - (PW+1)'(1);
              default: count <= count;
            endcase
          end
        end
        default: state <= VEC_LO;
      endcase
    end
  end

  assign bus.mem_addr    = mem_addr;
  assign bus.mem_rd      = mem_rd;
  assign bus.fetch_pc    = fetch_pc;
  assign bus.fetch_state = state;
  assign bus.ins_valid   = (count != '0);
  assign bus.ins_data    = q_data[rd_ptr];
  assign bus.ins_pc      = q_pc[rd_ptr];
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM model, boot timing table, scoreboard on the decoder stream.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  fetch_unit #(.ADDR_W(16), .DATA_W(8), .DEPTH(4), .RESET_VECTOR(16'hFFFC)) dut (
    .clk_in (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic        vld;
    logic [7:0]  data;
    logic [15:0] pc;
    logic [1:0]  st;
  } vec_t;

  logic [7:0] rom [65536];
  exp_t       sb [$];
  exp_t       e;
  vec_t       tbl [7];
  int         checks = 0;
  int         errors = 0;
  int         hs = 0;

  // One-cycle read latency; junk on the bus when no read was issued.
  always @(posedge clk) bus.mem_data <= (bus.mem_rd === 1'b1) ? rom[bus.mem_addr] : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.ins_valid === 1'b1 && bus.ins_ready === 1'b1) begin
      hs++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_unexpected actual=%h@%h required=none", bus.ins_data, bus.ins_pc);
      end else begin
        e = sb.pop_front();
        chk("stream_pc", 32'(bus.ins_pc), 32'(e.pc));
        chk("stream_data", 32'(bus.ins_data), 32'(e.data));
      end
    end
  end

  task automatic expect_stream(input logic [15:0] start, input int n);
    logic [15:0] a;
    exp_t x;
    sb.delete();
    a = start;
    for (int i = 0; i < n; i++) begin
      x.pc = a;
      x.data = rom[a];
      sb.push_back(x);
      a = a + 16'd1;
    end
  endtask

  // Entered and left at posedge+1. One reset edge, then the c1..c7 timing table.
  task automatic boot(input logic rdy);
    logic [15:0] vec;
    reset_n = 1'b0;
    bus.redirect = 1'b0;
    bus.ins_ready = rdy;
    @(posedge clk); #1;
    chk("rst_state", 32'(bus.fetch_state), 32'd0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_fetch_pc", 32'(bus.fetch_pc), 32'd0);
    chk("rst_valid", 32'(bus.ins_valid), 32'd0);
    vec = {rom[16'hFFFD], rom[16'hFFFC]};
    expect_stream(vec, 64);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk($sformatf("boot_c%0d_rd", i + 1), 32'(bus.mem_rd), 32'(tbl[i].rd));
      if (tbl[i].rd) chk($sformatf("boot_c%0d_addr", i + 1), 32'(bus.mem_addr), 32'(tbl[i].addr));
      chk($sformatf("boot_c%0d_valid", i + 1), 32'(bus.ins_valid), 32'(tbl[i].vld));
      chk($sformatf("boot_c%0d_state", i + 1), 32'(bus.fetch_state), 32'(tbl[i].st));
      if (tbl[i].vld) begin
        if (i == 6 && !rdy) begin
          chk("boot_c7_hold_data", 32'(bus.ins_data), 32'(rom[vec]));
          chk("boot_c7_hold_pc", 32'(bus.ins_pc), 32'(vec));
        end else begin
          chk($sformatf("boot_c%0d_data", i + 1), 32'(bus.ins_data), 32'(tbl[i].data));
          chk($sformatf("boot_c%0d_pc", i + 1), 32'(bus.ins_pc), 32'(tbl[i].pc));
        end
      end
    end
  endtask

  // Redirect asserted in cycle R, edge R samples it; checks R+1, R+2, R+4.
  task automatic redirect_to(input logic [15:0] tgt);
    bus.redirect = 1'b1;
    bus.redirect_pc = tgt;
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0;
    chk("redir_r1_valid", 32'(bus.ins_valid), 32'd0);
    chk("redir_r1_rd", 32'(bus.mem_rd), 32'd0);
    chk("redir_r1_fetch_pc", 32'(bus.fetch_pc), 32'(tgt));
    expect_stream(tgt, 32);
    @(posedge clk); #1;
    chk("redir_r2_rd", 32'(bus.mem_rd), 32'd1);
    chk("redir_r2_addr", 32'(bus.mem_addr), 32'(tgt));
    repeat (2) @(posedge clk);
    #1;
    chk("redir_r4_valid", 32'(bus.ins_valid), 32'd1);
    chk("redir_r4_pc", 32'(bus.ins_pc), 32'(tgt));
    chk("redir_r4_data", 32'(bus.ins_data), 32'(rom[tgt]));
  endtask

  initial begin
    int nrd;
    int hs0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0;
    bus.ins_ready = 1'b0;
    for (int a = 0; a < 65536; a++) rom[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    rom[16'hFFFC] = 8'h00;
    rom[16'hFFFD] = 8'h80;
    rom[16'h8000] = 8'hA0;
    rom[16'h8001] = 8'hFF;
    rom[16'hFFFE] = 8'h11;
    rom[16'hFFFF] = 8'h22;
    rom[16'h0000] = 8'h33;

    //          rd    addr       vld   data   pc         st
    tbl[0] = '{1'b1, 16'hFFFC, 1'b0, 8'h00, 16'h0000, 2'd1};
    tbl[1] = '{1'b1, 16'hFFFD, 1'b0, 8'h00, 16'h0000, 2'd2};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 2'd2};
    tbl[3] = '{1'b1, 16'h8000, 1'b0, 8'h00, 16'h0000, 2'd3};
    tbl[4] = '{1'b1, 16'h8001, 1'b0, 8'h00, 16'h0000, 2'd3};
    tbl[5] = '{1'b1, 16'h8002, 1'b1, 8'hA0, 16'h8000, 2'd3};
    tbl[6] = '{1'b1, 16'h8003, 1'b1, 8'hFF, 16'h8001, 2'd3};

    repeat (2) @(posedge clk);
    #1;

    // Vector boot and sustained one-byte-per-cycle streaming.
    boot(1'b1);
    hs0 = hs;
    repeat (10) @(posedge clk);
    #1;
    chk("boot_throughput", 32'(hs - hs0), 32'd10);

    // Backpressure: four reads only, head held, then drained in order.
    boot(1'b0);
    nrd = 0;
    repeat (10) begin
      @(posedge clk); #1;
      nrd += int'(bus.mem_rd);
    end
    chk("bp_extra_reads", 32'(nrd), 32'd0);
    chk("bp_valid", 32'(bus.ins_valid), 32'd1);
    chk("bp_head_pc", 32'(bus.ins_pc), 32'h8000);
    chk("bp_head_data", 32'(bus.ins_data), 32'hA0);
    bus.ins_ready = 1'b1;
    hs0 = hs;
    repeat (20) @(posedge clk);
    #1;
    chk("bp_drained_some", 32'(hs - hs0 >= 16), 32'd1);

    // Redirect while 8002 is landing and 8003 is on the bus.
    boot(1'b1);
    redirect_to(16'h9000);
    repeat (8) @(posedge clk);
    #1;

    // Address wrap through FFFF to 0000.
    redirect_to(16'hFFFE);
    repeat (6) @(posedge clk);
    #1;

    // Queue at two entries, pop + return + redirect in the same cycle.
    bus.ins_ready = 1'b0;
    @(posedge clk); #1;
    chk("sim_valid_before", 32'(bus.ins_valid), 32'd1);
    bus.ins_ready = 1'b1;
    redirect_to(16'hA000);
    repeat (6) @(posedge clk);
    #1;

    // Reset for one edge mid-stream; boot must repeat exactly.
    boot(1'b1);
    repeat (5) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
